// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional feature macro used by dmem_arbiter: DMEM_ARB_LOCK_EN (requester lock).
package dmem_arb_pkg;

  // Widths of the captured request payload; AW/DW of the arbiter must not exceed these.
  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } arb_req_t;

  // Requester-id width: $clog2 of the requester count, never below one bit.
  function automatic int unsigned arb_id_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid requester after last_gnt, wrapping.
module dmem_arbiter_rr_pick #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = 1
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last_gnt,
  output logic [N-1:0]   gnt_c,
  output logic [IDW-1:0] gnt_id_c,
  output logic           any_c
);

  logic [IDW-1:0] idx;

  // Scan (last_gnt+1) .. (last_gnt+N) mod N and keep the first hit.
  always_comb begin
    gnt_c    = '0;
    gnt_id_c = '0;
    any_c    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDW'((32'(last_gnt) + k) % N);
      if (!any_c && valid[idx]) begin
        any_c      = 1'b1;
        gnt_c[idx] = 1'b1;
        gnt_id_c   = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between NUM_REQ requesters.
// Each transaction runs IDLE -> ISSUE -> RESP; one accept at most every three cycles.
// Define DMEM_ARB_LOCK_EN to add rq_lock, which pins the grant to a locking owner.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = ARB_AW,
  parameter int unsigned DW      = ARB_DW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            rq_valid,
  output logic [NUM_REQ-1:0]            rq_ready,
  input  logic [NUM_REQ-1:0]            rq_we,
  input  logic [NUM_REQ-1:0][AW-1:0]    rq_addr,
  input  logic [NUM_REQ-1:0][DW-1:0]    rq_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            rq_lock,
`endif
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DW-1:0]                 rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic                          busy
);

  localparam int unsigned IDW = arb_id_w(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'(ARB_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ARB_ISSUE);
  localparam logic [1:0] S_RESP  = 2'(ARB_RESP);

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;      // last grant; also the owner of the in-flight txn
  arb_req_t           cap_q, cap_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0] ready_c;
  logic [NUM_REQ-1:0] pick_valid_c;
  logic [NUM_REQ-1:0] pick_gnt_c;
  logic [IDW-1:0]     pick_id_c;
  logic               pick_any_c;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;

  // A locked owner is the only requester allowed to compete.
  assign pick_valid_c = lock_q ? (rq_valid & (NUM_REQ'(1) << last_q)) : rq_valid;
`else
  assign pick_valid_c = rq_valid;
`endif

  dmem_arbiter_rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .valid    (pick_valid_c),
    .last_gnt (last_q),
    .gnt_c    (pick_gnt_c),
    .gnt_id_c (pick_id_c),
    .any_c    (pick_any_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cap_d       = cap_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    ready_c     = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_any_c) begin
          ready_c     = pick_gnt_c;
          cap_d.we    = rq_we[pick_id_c];
          cap_d.addr  = ARB_AW'(rq_addr[pick_id_c]);
          cap_d.wdata = ARB_DW'(rq_wdata[pick_id_c]);
          last_d      = pick_id_c;
          mem_en_d    = 1'b1;
          mem_we_d    = rq_we[pick_id_c];
`ifdef DMEM_ARB_LOCK_EN
          lock_d      = rq_lock[pick_id_c];
`endif
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rsp_valid_d = NUM_REQ'(1) << last_q;
        rsp_rdata_d = cap_q.we ? '0 : mem_rdata;
        state_d     = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      last_q      <= IDW'(NUM_REQ - 1);
      cap_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cap_q       <= cap_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  // Reset kills grant and strobe in the same cycle, so an in-flight write never lands.
  assign rq_ready  = reset_n ? ready_c : '0;
  assign mem_en    = mem_en_q & reset_n;
  assign mem_we    = mem_we_q & reset_n;
  assign mem_addr  = AW'(cap_q.addr);
  assign mem_wdata = DW'(cap_q.wdata);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic                  clk;
  logic                  reset_n;
  logic [NR-1:0]         rq_valid;
  logic [NR-1:0]         rq_ready;
  logic [NR-1:0]         rq_we;
  logic [NR-1:0][AW-1:0] rq_addr;
  logic [NR-1:0][DW-1:0] rq_wdata;
  logic [NR-1:0]         rq_lock;
  logic [NR-1:0]         rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_rdata;
  logic                  busy;

  dmem_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_we     (rq_we),
    .rq_addr   (rq_addr),
    .rq_wdata  (rq_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .rq_lock   (rq_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT: combinational read, clocked write.
  logic [31:0] dmem    [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_en && mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: one transaction in flight, accepted at acc_c.
  int          acc_c = -100;
  int          acc_id;
  bit          acc_we;
  logic [31:0] acc_addr, acc_wdata, acc_rdata;
  int          m_last   = NR - 1;
  bit          m_locked = 1'b0;

  // Requester behaviour knobs.
  logic [NR-1:0] rearm = '0;
  bit            lock_mode = 1'b0;
  int            lock_cnt  = 0;

  // Observed DUT events.
  longint g_cyc[$], g_id[$], r_cyc[$], r_id[$], r_dat[$], s_cyc[$], s_we[$], s_addr[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint qget(input longint q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    g_cyc.delete(); g_id.delete(); r_cyc.delete(); r_id.delete();
    r_dat.delete(); s_cyc.delete(); s_we.delete(); s_addr.delete();
  endtask

  task automatic raise(input int i, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit lk);
    rq_valid[i] = 1'b1;
    rq_we[i]    = we;
    rq_addr[i]  = addr;
    rq_wdata[i] = wd;
    rq_lock[i]  = lk;
  endtask

  // What a requester does right after its request was accepted.
  task automatic post_accept(input int w);
    if (lock_mode && w == 1) begin
      lock_cnt++;
      if (lock_cnt < 4) raise(1, 1'b0, 32'h40 + 32'(lock_cnt) * 4, 32'h0, lock_cnt < 3);
      else rq_valid[1] = 1'b0;
    end else if (rearm[w]) begin
      raise(w, 1'b0, 32'($urandom_range(0, 15)) << 2, $urandom, 1'b0);
    end else begin
      rq_valid[w] = 1'b0;
    end
  endtask

  // One clock: observe and check at negedge, advance the model, then let requesters react.
  task automatic tick();
    bit            issue, resp;
    int            w;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (rq_ready[i])  begin g_cyc.push_back(cyc); g_id.push_back(i); end
      if (rsp_valid[i]) begin r_cyc.push_back(cyc); r_id.push_back(i); r_dat.push_back(longint'(rsp_rdata)); end
    end
    if (mem_en) begin
      s_cyc.push_back(cyc); s_we.push_back(longint'(mem_we)); s_addr.push_back(longint'(mem_addr));
    end
    issue = (cyc == acc_c + 1);
    resp  = (cyc == acc_c + 2);
    w = -1;
    if (reset_n && !issue && !resp)
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_last + k) % NR;
        if (w < 0 && rq_valid[i] && (!m_locked || i == m_last)) w = i;
      end
    exp_ready = (w >= 0) ? (NR'(1) << w) : '0;
    check("rq_ready", rq_ready, exp_ready);
    check("mem_en", mem_en, issue && reset_n);
    check("mem_we", mem_we, issue && reset_n && acc_we);
    if (issue && reset_n) begin
      check("mem_addr", mem_addr, acc_addr);
      check("mem_wdata", mem_wdata, acc_wdata);
      if (acc_we) ref_mem[acc_addr[7:2]] = acc_wdata;
    end
    check("rsp_valid", rsp_valid, resp ? (NR'(1) << acc_id) : '0);
    if (resp) check("rsp_rdata", rsp_rdata, acc_rdata);
    check("busy", busy, issue || resp);
    if (!reset_n) begin
      acc_c = -100; m_last = NR - 1; m_locked = 1'b0;
    end else if (w >= 0) begin
      acc_c     = cyc;
      acc_id    = w;
      acc_we    = rq_we[w];
      acc_addr  = rq_addr[w];
      acc_wdata = rq_wdata[w];
      acc_rdata = rq_we[w] ? 32'h0 : ref_mem[rq_addr[w][7:2]];
      m_last    = w;
      m_locked  = rq_lock[w];
    end
    @(posedge clk);
    #1;
    cyc++;
    if (w >= 0) post_accept(w);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int left;
    left = budget;
    while (g_id.size() < n && left > 0) begin
      tick();
      left--;
    end
    if (g_id.size() < n) check("grant_timeout", 64'(g_id.size()), 64'(n));
  endtask

  task automatic drain();
    rearm = '0;
    rq_valid = '0;
    repeat (4) tick();
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; rq_valid = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0; rq_lock = '0;

    // Reset with every requester valid; req 0 wins first after release.
    for (int i = 0; i < NR; i++) raise(i, 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    clear_logs();
    wait_grants(1, 5);
    check("first_grant", qget(g_id, 0), 0);
    drain();

    // Write from req 0, read back from req 1.
    clear_logs();
    raise(0, 1'b1, 32'h10, 32'hCAFEBABE, 1'b0);
    wait_grants(1, 5);
    repeat (3) tick();
    check("wr_grant", qget(g_id, 0), 0);
    check("wr_strobe_lat", qget(s_cyc, 0), qget(g_cyc, 0) + 1);
    check("wr_strobe_we", qget(s_we, 0), 1);
    check("wr_strobe_addr", qget(s_addr, 0), 32'h10);
    check("wr_rsp_lat", qget(r_cyc, 0), qget(g_cyc, 0) + 2);
    check("wr_rsp_id", qget(r_id, 0), 0);
    clear_logs();
    raise(1, 1'b0, 32'h10, 32'h0, 1'b0);
    wait_grants(1, 5);
    repeat (3) tick();
    check("rd_rsp_id", qget(r_id, 0), 1);
    check("rd_rsp_data", qget(r_dat, 0), 32'hCAFEBABE);
    check("rd_rsp_lat", qget(r_cyc, 0) - qget(g_cyc, 0), 2);
    drain();

    // Both requesters continuously valid: strict alternation, 3-cycle spacing.
    clear_logs();
    rearm = '1;
    raise(0, 1'b0, 32'h4, 32'h0, 1'b0);
    raise(1, 1'b0, 32'h8, 32'h0, 1'b0);
    wait_grants(6, 30);
    drain();
    for (int k = 0; k < 6; k++) check($sformatf("rot_id%0d", k), qget(g_id, k), k % 2);
    for (int k = 1; k < 6; k++) check($sformatf("rot_gap%0d", k), qget(g_cyc, k) - qget(g_cyc, k - 1), 3);

    // Reset while a write is in ISSUE: no response, no memory write.
    clear_logs();
    raise(0, 1'b1, 32'h20, 32'h1, 1'b0);
    wait_grants(1, 5);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    check("rstmid_rsp", 64'(r_id.size()), 0);
    check("rstmid_strobe", 64'(s_cyc.size()), 0);
    clear_logs();
    raise(0, 1'b0, 32'h20, 32'h0, 1'b0);
    raise(1, 1'b0, 32'h24, 32'h0, 1'b0);
    wait_grants(2, 10);
    drain();
    check("rstmid_first", qget(g_id, 0), 0);
    check("rstmid_rdata", qget(r_dat, 0), 0);

`ifdef DMEM_ARB_LOCK_EN
    // Locked owner keeps the memory through three locked reads plus the unlocking one.
    clear_logs();
    lock_mode = 1'b1; lock_cnt = 0;
    raise(1, 1'b0, 32'h40, 32'h0, 1'b1);
    wait_grants(1, 5);
    raise(0, 1'b0, 32'h60, 32'h0, 1'b0);
    wait_grants(5, 40);
    lock_mode = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) check($sformatf("lock_id%0d", k), qget(g_id, k), (k < 4) ? 1 : 0);
`endif

    // Req 1 withdraws while req 0 owns the FSM; req 0 is served again, req 1 never answered.
    clear_logs();
    raise(0, 1'b0, 32'h50, 32'h0, 1'b0);
    wait_grants(1, 5);
    raise(1, 1'b0, 32'h54, 32'h0, 1'b0);
    tick();
    rq_valid[1] = 1'b0;
    raise(0, 1'b0, 32'h58, 32'h0, 1'b0);
    wait_grants(2, 5);
    drain();
    check("drop_grant", qget(g_id, 1), 0);
    cnt = 0;
    foreach (r_id[i]) if (r_id[i] == 1) cnt++;
    check("drop_no_rsp1", 64'(cnt), 0);
    check("drop_rsp_cnt", 64'(r_id.size()), 2);

    // Randomized traffic with withdrawals and occasional resets.
    for (int n = 0; n < 600; n++) begin
      tick();
      reset_n = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!rq_valid[i] && $urandom_range(0, 2) == 0)
          raise(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 1'b0);
        else if (rq_valid[i] && $urandom_range(0, 9) == 0)
          rq_valid[i] = 1'b0;
      end
    end
    reset_n = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
